// File: rtl/bram_width_adapter.sv
// Narrow valid/ready register-bus port onto a wide single-port BRAM. Writes are
// byte-granular into one lane of a line. Reads extract one lane after the BRAM read latency.
// Latency: write/error (and cache hit) respond 1 cycle after accept; read miss after READ_LATENCY+1.
// Backpressure: one transaction in flight; req_ready_o is low until the response is taken by rsp_ready_i.
//
// Optional feature: define BRAM_WIDTH_ADAPTER_LINE_CACHE_EN for a one-line read cache.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   req_*                    narrow request (valid/ready, we, word address, wdata, byte enables)
//   rsp_*                    registered response (valid/ready, rdata, out-of-range error)
//   *_bram_o / dout_bram_i   wide BRAM port (enable, write enable, line address, data, byte enables)
module bram_width_adapter #(
    parameter int unsigned BRAM_DWIDTH  = 128,
    parameter int unsigned NARROW_WIDTH = 32,
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned READ_LATENCY = 1,
    localparam int unsigned RATIO       = BRAM_DWIDTH / NARROW_WIDTH,
    localparam int unsigned LANE_W      = $clog2(RATIO),
    localparam int unsigned ADDR_WIDTH  = $clog2(DEPTH),
    localparam int unsigned NBE         = NARROW_WIDTH / 8,
    localparam int unsigned BBE         = BRAM_DWIDTH / 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic                         req_we_i,
    input  logic [ADDR_WIDTH+LANE_W-1:0] req_addr_i,
    input  logic [NARROW_WIDTH-1:0]      req_wdata_i,
    input  logic [NBE-1:0]               req_be_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [NARROW_WIDTH-1:0]      rsp_rdata_o,
    output logic                         rsp_err_o,
    output logic                         en_bram_o,
    output logic                         we_bram_o,
    output logic [ADDR_WIDTH-1:0]        addr_bram_o,
    output logic [BRAM_DWIDTH-1:0]       din_bram_o,
    output logic [BBE-1:0]               be_bram_o,
    input  logic [BRAM_DWIDTH-1:0]       dout_bram_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_e;

    // READ_LATENCY is 1..4, so the remaining-cycles counter fits in 2 bits.
    localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

    state_e                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [NARROW_WIDTH-1:0] rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [ADDR_WIDTH-1:0]   req_line;
    logic [LANE_W-1:0]       req_lane;
    logic                    req_oor;

    logic                    bram_en, bram_we;
    logic [ADDR_WIDTH-1:0]   bram_addr;
    logic [BRAM_DWIDTH-1:0]  bram_din;
    logic [BBE-1:0]          bram_be;

    logic                    cache_hit;
    logic [NARROW_WIDTH-1:0] cache_rdata;

    // Lane-indexed views of the wide words avoid multiplying the lane index
    // inside a part-select.
    logic [RATIO-1:0][NARROW_WIDTH-1:0] dout_lanes;
    logic [RATIO-1:0][NBE-1:0]          be_lanes;

    assign dout_lanes = dout_bram_i;
    assign req_line   = req_addr_i[LANE_W +: ADDR_WIDTH];
    assign req_lane   = req_addr_i[LANE_W-1:0];
    // DEPTH need not be a power of two, so the top lines of the address
    // space may not exist.
    assign req_oor    = 32'(req_line) >= DEPTH;

    always_comb begin
        be_lanes           = '0;
        be_lanes[req_lane] = req_be_i;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lane_d    = lane_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_din  = '0;
        bram_be   = '0;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    lane_d = req_lane;
                    if (req_oor) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end else if (req_we_i) begin
                        err_d   = 1'b0;
                        rdata_d = '0;
                        state_d = RESP;
                        // An all-zero byte mask still gets a response but
                        // leaves the BRAM idle.
                        if (|req_be_i) begin
                            bram_en   = 1'b1;
                            bram_we   = 1'b1;
                            bram_addr = req_line;
                            bram_din  = {RATIO{req_wdata_i}};
                            bram_be   = be_lanes;
                        end
                    end else if (cache_hit) begin
                        err_d   = 1'b0;
                        rdata_d = cache_rdata;
                        state_d = RESP;
                    end else begin
                        err_d     = 1'b0;
                        bram_en   = 1'b1;
                        bram_addr = req_line;
                        cnt_d     = CNT_INIT;
                        state_d   = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                // Counter reaching 0 marks the cycle dout_bram_i is valid.
                if (cnt_q == 2'd0) begin
                    rdata_d = dout_lanes[lane_q];
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lane_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

`ifdef BRAM_WIDTH_ADAPTER_LINE_CACHE_EN
    logic                               cvld_q, cvld_d;
    logic [ADDR_WIDTH-1:0]              ctag_q, ctag_d;
    logic [BRAM_DWIDTH-1:0]             cdata_q, cdata_d;
    logic [ADDR_WIDTH-1:0]              line_q, line_d;
    logic [RATIO-1:0][NARROW_WIDTH-1:0] cache_lanes;

    assign cache_lanes = cdata_q;
    assign cache_hit   = cvld_q && (ctag_q == req_line);
    assign cache_rdata = cache_lanes[req_lane];

    always_comb begin
        cvld_d  = cvld_q;
        ctag_d  = ctag_q;
        cdata_d = cdata_q;
        line_d  = line_q;
        if (state_q == IDLE && req_valid_i && !req_oor) begin
            if (req_we_i && cache_hit) begin
                // Keep the cached copy coherent with the BRAM by merging
                // exactly the bytes being written.
                for (int b = 0; b < int'(BBE); b++) begin
                    if (bram_be[b]) begin
                        cdata_d[8*b +: 8] = bram_din[8*b +: 8];
                    end
                end
            end else if (!req_we_i && !cache_hit) begin
                line_d = req_line;
            end
        end
        if (state_q == RD_WAIT && cnt_q == 2'd0) begin
            cvld_d  = 1'b1;
            ctag_d  = line_q;
            cdata_d = dout_bram_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cvld_q  <= 1'b0;
            ctag_q  <= '0;
            cdata_q <= '0;
            line_q  <= '0;
        end else begin
            cvld_q  <= cvld_d;
            ctag_q  <= ctag_d;
            cdata_q <= cdata_d;
            line_q  <= line_d;
        end
    end
`else
    assign cache_hit   = 1'b0;
    assign cache_rdata = '0;
`endif

    // Outputs are forced quiet while reset is held, not just after the
    // first reset edge.
    assign req_ready_o = rst_ni && (state_q == IDLE);
    assign rsp_valid_o = rst_ni && (state_q == RESP);
    assign rsp_rdata_o = rst_ni ? rdata_q : '0;
    assign rsp_err_o   = rst_ni && err_q;
    assign en_bram_o   = rst_ni && bram_en;
    assign we_bram_o   = rst_ni && bram_we;
    assign addr_bram_o = rst_ni ? bram_addr : '0;
    assign din_bram_o  = rst_ni ? bram_din : '0;
    assign be_bram_o   = rst_ni ? bram_be : '0;

endmodule

// File: tb/tb_bram_width_adapter.sv
module tb_bram_width_adapter;
    localparam int BW     = 128;
    localparam int NW     = 32;
    localparam int DEPTH  = 24;
    localparam int RL     = 3;
    localparam int RATIO  = BW / NW;
    localparam int LW     = 2;
    localparam int AW     = 5;
    localparam int NBE    = NW / 8;
    localparam int BBE    = BW / 8;
    localparam int NWORDS = DEPTH * RATIO;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              req_valid, req_ready, req_we;
    logic [AW+LW-1:0]  req_addr;
    logic [NW-1:0]     req_wdata;
    logic [NBE-1:0]    req_be;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [NW-1:0]     rsp_rdata;
    logic              en_bram, we_bram;
    logic [AW-1:0]     addr_bram;
    logic [BW-1:0]     din_bram, dout_bram;
    logic [BBE-1:0]    be_bram;

    bram_width_adapter #(
        .BRAM_DWIDTH (BW),
        .NARROW_WIDTH(NW),
        .DEPTH       (DEPTH),
        .READ_LATENCY(RL)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_we_i   (req_we),
        .req_addr_i (req_addr),
        .req_wdata_i(req_wdata),
        .req_be_i   (req_be),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o  (rsp_err),
        .en_bram_o  (en_bram),
        .we_bram_o  (we_bram),
        .addr_bram_o(addr_bram),
        .din_bram_o (din_bram),
        .be_bram_o  (be_bram),
        .dout_bram_i(dout_bram)
    );

    // BRAM environment: byte-enabled writes, reads delivered RL cycles after
    // the enable; outside that slot the read data is X so mistimed captures show.
    logic [BW-1:0] bram_mem [DEPTH];
    logic [BW-1:0] rd_pipe  [RL];
    assign dout_bram = rd_pipe[RL-1];

    always @(posedge clk) begin
        for (int i = RL - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= (en_bram && !we_bram) ? bram_mem[addr_bram] : 'x;
        if (en_bram && we_bram) begin
            for (int b = 0; b < BBE; b++)
                if (be_bram[b]) bram_mem[addr_bram][8*b +: 8] <= din_bram[8*b +: 8];
        end
    end

    // Reference model: flat array of narrow words plus the identity of the cached line.
    logic [NW-1:0] ref_mem [NWORDS];
    bit            ref_cvld;
    int            ref_cline;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req_ready"}, BW'(req_ready), BW'(0));
        chk({tag, "_rsp_valid"}, BW'(rsp_valid), BW'(0));
        chk({tag, "_rsp_err"},   BW'(rsp_err),   BW'(0));
        chk({tag, "_rsp_rdata"}, BW'(rsp_rdata), BW'(0));
        chk({tag, "_bram_ctl"},  BW'({en_bram, we_bram, be_bram}), BW'(0));
    endtask

    // Entered at a negedge with the DUT idle; leaves at a negedge with it idle again.
    task automatic txn(input bit we, input logic [AW+LW-1:0] a, input logic [NW-1:0] wd,
                       input logic [NBE-1:0] be, input int dly);
        int line, lane, cyc, exp_lat;
        bit err, hit, exp_en, extra_en, got;
        logic [NW-1:0] exp_rd;
        logic [BBE-1:0] exp_be;
        line = int'(a) / RATIO;
        lane = int'(a) % RATIO;
        err  = line >= DEPTH;
        hit  = 1'b0;
`ifdef BRAM_WIDTH_ADAPTER_LINE_CACHE_EN
        hit  = !we && !err && ref_cvld && ref_cline == line;
`endif
        exp_en  = !err && !hit && !(we && be == 0);
        exp_lat = (we || err || hit) ? 1 : RL + 1;
        exp_rd  = (we || err) ? '0 : ref_mem[a];
        exp_be  = BBE'(be) << (lane * NBE);

        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        #1;
        chk("accept_ready", BW'(req_ready), BW'(1));
        chk("bram_en", BW'(en_bram), BW'(exp_en));
        chk("bram_we", BW'(we_bram), BW'(exp_en && we));
        if (exp_en) chk("bram_addr", BW'(addr_bram), BW'(line));
        if (exp_en && we) begin
            chk("bram_be", BW'(be_bram), BW'(exp_be));
            chk("bram_din", din_bram, {RATIO{wd}});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;

        cyc = 0; got = 1'b0; extra_en = 1'b0;
        while (!got && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (en_bram) extra_en = 1'b1;
            if (rsp_valid) got = 1'b1;
        end
        chk("rsp_latency", BW'(cyc), BW'(exp_lat));
        chk("no_late_bram_en", BW'(extra_en), BW'(0));
        if (got) begin
            chk("rsp_rdata", BW'(rsp_rdata), BW'(exp_rd));
            chk("rsp_err", BW'(rsp_err), BW'(err));
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                chk("hold_valid", BW'(rsp_valid), BW'(1));
                chk("hold_rdata", BW'(rsp_rdata), BW'(exp_rd));
                chk("hold_err", BW'(rsp_err), BW'(err));
                chk("hold_req_ready", BW'(req_ready), BW'(0));
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            @(negedge clk);
            chk("ready_after_rsp", BW'(req_ready), BW'(1));
            chk("valid_after_rsp", BW'(rsp_valid), BW'(0));
        end

        if (!err && we) begin
            for (int b = 0; b < NBE; b++)
                if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
        end
        if (!err && !we && !hit) begin
            ref_cvld  = 1'b1;
            ref_cline = line;
        end
    endtask

    initial begin
        logic [NW-1:0] w [RATIO];
        int miss_line;
        bit late_rsp, not_ready;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
        ref_cvld = 1'b0; ref_cline = 0;
        for (int l = 0; l < DEPTH; l++) begin
            for (int k = 0; k < RATIO; k++) begin
                w[k] = $urandom;
                ref_mem[l*RATIO + k] = w[k];
            end
            bram_mem[l] = {w[3], w[2], w[1], w[0]};
        end

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", BW'(req_ready), BW'(1));

        // Full-lane write to the top lane of line 5, then read it back.
        txn(1'b1, 7'h17, 32'hDEADBEEF, 4'hF, 0);
        txn(1'b0, 7'h17, '0, 4'h0, 0);
        // Single-byte write, then confirm only byte 1 changed.
        txn(1'b1, 7'h04, 32'h0000AB00, 4'h2, 0);
        txn(1'b0, 7'h04, '0, 4'h0, 1);
        // Known lane-1 pattern, response held off for 3 cycles.
        bram_mem[0][63:32] = 32'h12345678;
        ref_mem[1]         = 32'h12345678;
        txn(1'b0, 7'h01, '0, 4'h0, 3);
        // Out-of-range line 25 and a write with no byte enables.
        txn(1'b0, 7'h64, '0, 4'h0, 0);
        txn(1'b1, 7'h64, 32'h55AA55AA, 4'hF, 1);
        txn(1'b1, 7'h10, 32'hFFFFFFFF, 4'h0, 0);
        txn(1'b0, 7'h10, '0, 4'h0, 0);
        // Same-line read pair and a write into the line just read.
        txn(1'b0, 7'h08, '0, 4'h0, 0);
        txn(1'b0, 7'h09, '0, 4'h0, 0);
        txn(1'b1, 7'h09, 32'hCAFE0000, 4'hF, 0);
        txn(1'b0, 7'h09, '0, 4'h0, 0);
        txn(1'b0, 7'h0B, '0, 4'h0, 2);

        // Reset while a read is waiting on the BRAM.
        miss_line = (ref_cvld && ref_cline == 20) ? 19 : 20;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 7'(miss_line * RATIO + 2); req_be = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_quiet("rst_in_rdwait");
        @(posedge clk);
        @(negedge clk);
        chk_quiet("rst_next_cycle");
        rst_n = 1'b1;
        ref_cvld = 1'b0;
        late_rsp = 1'b0; not_ready = 1'b0;
        for (int i = 0; i < RL + 3; i++) begin
            @(negedge clk);
            if (rsp_valid) late_rsp = 1'b1;
            if (!req_ready) not_ready = 1'b1;
        end
        chk("no_late_rsp", BW'(late_rsp), BW'(0));
        chk("idle_after_rst", BW'(not_ready), BW'(0));
        txn(1'b0, 7'h08, '0, 4'h0, 0);

        // Randomized traffic, mostly on a few lines so the cache sees hits and merges.
        for (int t = 0; t < 80; t++) begin
            logic [AW+LW-1:0] a;
            a = ($urandom % 6 == 0) ? 7'($urandom) : 7'($urandom % 16);
            txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom % 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
